// File: rtl/ffe_pkg.sv
// rtl/ffe_pkg.sv - shared types and width derivations for the time-multiplexed FFE
package ffe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } ffe_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Wide enough that NUM_TAPS full-scale products can never overflow.
    function automatic int acc_width(input int data_w, input int addr_w);
        return 2 * data_w + addr_w;
    endfunction

    function automatic int round_const(input int frac);
        return 1 << (frac - 1);
    endfunction

endpackage

// File: rtl/ffe_round_sat.sv
// rtl/ffe_round_sat.sv - round half toward +inf, drop fraction bits, clamp to output width
module ffe_round_sat
    import ffe_pkg::*;
#(
    parameter int IN_W      = 26,
    parameter int DATA_W    = 12,
    parameter int COEF_FRAC = 10
) (
    input  logic signed [IN_W-1:0]   acc,
    output logic signed [DATA_W-1:0] y
);

    localparam int RND = round_const(COEF_FRAC);
    localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;

    assign sum     = {acc[IN_W-1], acc} + (IN_W+1)'(RND);
    assign shifted = sum >>> COEF_FRAC;

    always_comb begin
        y = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            y = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            y = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/ffe_tdm_mac.sv
// rtl/ffe_tdm_mac.sv - FFE with one shared MAC, one tap per clock, double-buffered coefficients
module ffe_tdm_mac
    import ffe_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int NUM_TAPS  = 4,
    parameter int COEF_FRAC = 10,
    localparam int ADDR_W   = clog2(NUM_TAPS)
) (
    input  logic                     ffe_clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] d_in,
    input  logic                     coef_wr_en,
    input  logic [ADDR_W-1:0]        coef_wr_addr,
    input  logic signed [DATA_W-1:0] coef_wr_data,
    input  logic                     coef_commit,
    input  logic                     overrun_clr,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] y,
    output logic                     overrun
);

    localparam int ACC_W  = acc_width(DATA_W, ADDR_W);
    localparam int PROD_W = 2 * DATA_W;

    ffe_state_t               state;
    logic signed [DATA_W-1:0] x_line   [NUM_TAPS];
    logic signed [DATA_W-1:0] c_shadow [NUM_TAPS];
    logic signed [DATA_W-1:0] c_act    [NUM_TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [ADDR_W-1:0]        tap;
    logic                     commit_pend;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] y_next;
    logic                     busy_hit;
    logic                     wr_hit;

    assign busy_hit = (state != IDLE) && in_valid;
    assign wr_hit   = coef_wr_en && ({1'b0, coef_wr_addr} < (ADDR_W+1)'(NUM_TAPS));
    assign prod     = PROD_W'(x_line[tap]) * PROD_W'(c_act[tap]);

    ffe_round_sat #(
        .IN_W     (ACC_W),
        .DATA_W   (DATA_W),
        .COEF_FRAC(COEF_FRAC)
    ) u_round_sat (
        .acc(acc),
        .y  (y_next)
    );

    always_ff @(posedge ffe_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            tap         <= '0;
            commit_pend <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            y           <= '0;
            overrun     <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                x_line[i]   <= '0;
                c_shadow[i] <= '0;
                c_act[i]    <= '0;
            end
        end else begin
            if (wr_hit) begin
                c_shadow[coef_wr_addr] <= coef_wr_data;
            end
            // Copy only while idle so a computation never sees a half-updated bank.
            if (state == IDLE && commit_pend) begin
                c_act <= c_shadow;
            end
            commit_pend <= coef_commit || (commit_pend && state != IDLE);

            if (busy_hit) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_line[0] <= d_in;
                        for (int i = 1; i < NUM_TAPS; i++) begin
                            x_line[i] <= x_line[i-1];
                        end
                        acc      <= '0;
                        tap      <= '0;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    tap <= tap + 1'b1;
                    if (tap == ADDR_W'(NUM_TAPS - 1)) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    y         <= y_next;
                    out_valid <= 1'b1;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ffe_tdm_mac.sv
// tb/tb_ffe_tdm_mac.sv - self-checking bench for ffe_tdm_mac with an arithmetic reference model
module tb_ffe_tdm_mac;

    localparam int DATA_W    = 12;
    localparam int NUM_TAPS  = 4;
    localparam int COEF_FRAC = 10;
    localparam int ADDR_W    = 2;
    localparam int Y_MAX     = 2 ** (DATA_W - 1) - 1;
    localparam int Y_MIN     = -(2 ** (DATA_W - 1));

    logic                     ffe_clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] d_in;
    logic                     coef_wr_en;
    logic [ADDR_W-1:0]        coef_wr_addr;
    logic signed [DATA_W-1:0] coef_wr_data;
    logic                     coef_commit;
    logic                     overrun_clr;
    logic                     out_valid;
    logic signed [DATA_W-1:0] y;
    logic                     overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int mx [NUM_TAPS];
    int mc [NUM_TAPS];
    int ms [NUM_TAPS];
    bit m_pend;
    int m_y;

    ffe_tdm_mac #(
        .DATA_W   (DATA_W),
        .NUM_TAPS (NUM_TAPS),
        .COEF_FRAC(COEF_FRAC)
    ) dut (
        .ffe_clk     (ffe_clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .d_in        (d_in),
        .coef_wr_en  (coef_wr_en),
        .coef_wr_addr(coef_wr_addr),
        .coef_wr_data(coef_wr_data),
        .coef_commit (coef_commit),
        .overrun_clr (overrun_clr),
        .out_valid   (out_valid),
        .y           (y),
        .overrun     (overrun)
    );

    always #5 ffe_clk = ~ffe_clk;

    // Filter output as plain math: floor((sum + half) / 2^frac), then clamp.
    function automatic int model_rs(input longint a);
        longint r;
        r = (a + (longint'(1) << (COEF_FRAC - 1))) >>> COEF_FRAC;
        if (r > Y_MAX) return Y_MAX;
        if (r < Y_MIN) return Y_MIN;
        return int'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_TAPS; i++) begin
            mx[i] = 0;
            mc[i] = 0;
            ms[i] = 0;
        end
        m_pend = 1'b0;
        m_y    = 0;
    endtask

    task automatic model_accept(input int d);
        longint sum;
        if (m_pend) begin
            mc     = ms;
            m_pend = 1'b0;
        end
        for (int i = NUM_TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = d;
        sum = 0;
        for (int i = 0; i < NUM_TAPS; i++) sum += longint'(mx[i]) * longint'(mc[i]);
        m_y = model_rs(sum);
    endtask

    task automatic do_reset();
        @(negedge ffe_clk);
        rst = 1'b1;
        repeat (2) @(negedge ffe_clk);
        rst = 1'b0;
        model_reset();
        @(negedge ffe_clk);
    endtask

    task automatic write_coef(input int idx, input int v);
        coef_wr_en   = 1'b1;
        coef_wr_addr = ADDR_W'(idx);
        coef_wr_data = DATA_W'(v);
        @(negedge ffe_clk);
        coef_wr_en = 1'b0;
        ms[idx]    = v;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        @(negedge ffe_clk);
        coef_commit = 1'b0;
        m_pend      = 1'b1;
    endtask

    task automatic load_bank(input int c0, input int c1, input int c2, input int c3);
        write_coef(0, c0);
        write_coef(1, c1);
        write_coef(2, c2);
        write_coef(3, c3);
        commit();
    endtask

    task automatic accept_sample(input int d);
        in_valid = 1'b1;
        d_in     = DATA_W'(d);
        @(negedge ffe_clk);
        in_valid = 1'b0;
        model_accept(d);
    endtask

    task automatic wait_result(output int got, output int lat);
        lat = -1;
        got = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge ffe_clk);
            if (out_valid === 1'b1) begin
                lat = i;
                got = y;
                break;
            end
        end
    endtask

    task automatic send_sample(input int d, output int got);
        int lat;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL ready_before_send: in_ready=%b required 1", in_ready);
        else pass_cnt++;
        accept_sample(d);
        wait_result(got, lat);
        total_cnt++;
        if (lat != NUM_TAPS + 1) $display("FAIL latency d=%0d: got %0d cycles required %0d", d, lat, NUM_TAPS + 1);
        else pass_cnt++;
        total_cnt++;
        if (got != m_y) $display("FAIL model_y d=%0d: y=%0d required %0d", d, got, m_y);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge ffe_clk);
        total_cnt++;
        if (y !== '0 || out_valid !== 1'b0 || overrun !== 1'b0)
            $display("FAIL reset_outputs: y=%0d out_valid=%b overrun=%b required 0/0/0", y, out_valid, overrun);
        else pass_cnt++;
        rst = 1'b0;
        model_reset();
        @(negedge ffe_clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_identity();
        int got;
        load_bank(1024, 0, 0, 0);
        send_sample(100, got);
        total_cnt++;
        if (got != 100) $display("FAIL identity_pos: y=%0d required 100", got);
        else pass_cnt++;
        send_sample(-200, got);
        total_cnt++;
        if (got != -200) $display("FAIL identity_neg: y=%0d required -200", got);
        else pass_cnt++;
        @(negedge ffe_clk);
        total_cnt++;
        if (out_valid !== 1'b0 || y !== -12'sd200)
            $display("FAIL strobe_and_hold: out_valid=%b y=%0d required 0 and -200", out_valid, y);
        else pass_cnt++;
    endtask

    task automatic test_impulse();
        int got;
        int smp [4] = '{1000, 0, 0, 0};
        int exp [4] = '{1000, 500, -250, 125};
        do_reset();
        load_bank(1024, 512, -256, 128);
        for (int i = 0; i < 4; i++) begin
            send_sample(smp[i], got);
            total_cnt++;
            if (got != exp[i]) $display("FAIL impulse[%0d]: y=%0d required %0d", i, got, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_rounding();
        int got;
        load_bank(512, 0, 0, 0);
        send_sample(3, got);
        total_cnt++;
        if (got != 2) $display("FAIL round_pos_half: y=%0d required 2", got);
        else pass_cnt++;
        send_sample(-3, got);
        total_cnt++;
        if (got != -1) $display("FAIL round_neg_half: y=%0d required -1", got);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        int got;
        load_bank(1023, 1023, 1023, 1023);
        for (int i = 0; i < 4; i++) send_sample(2047, got);
        total_cnt++;
        if (got != 2047) $display("FAIL sat_high: y=%0d required 2047", got);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) send_sample(-2048, got);
        total_cnt++;
        if (got != -2048) $display("FAIL sat_low: y=%0d required -2048", got);
        else pass_cnt++;
    endtask

    task automatic test_overrun_commit();
        int got;
        int lat;
        do_reset();
        load_bank(1024, 1024, 0, 0);
        accept_sample(50);
        @(negedge ffe_clk);
        in_valid     = 1'b1;
        d_in         = 12'sd777;
        coef_wr_en   = 1'b1;
        coef_wr_addr = 2'd0;
        coef_wr_data = -12'sd1024;
        coef_commit  = 1'b1;
        @(negedge ffe_clk);
        in_valid    = 1'b0;
        coef_wr_en  = 1'b0;
        coef_commit = 1'b0;
        ms[0]       = -1024;
        m_pend      = 1'b1;
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: overrun=%b required 1", overrun);
        else pass_cnt++;
        wait_result(got, lat);
        total_cnt++;
        if (lat != 3 || got != 50) $display("FAIL old_bank_result: y=%0d lat=%0d required 50 lat 3", got, lat);
        else pass_cnt++;
        send_sample(60, got);
        total_cnt++;
        if (got != -10) $display("FAIL new_bank_result: y=%0d required -10", got);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL overrun_sticky: overrun=%b required 1", overrun);
        else pass_cnt++;
        overrun_clr = 1'b1;
        @(negedge ffe_clk);
        overrun_clr = 1'b0;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL overrun_clear: overrun=%b required 0", overrun);
        else pass_cnt++;
        accept_sample(5);
        in_valid    = 1'b1;
        overrun_clr = 1'b1;
        @(negedge ffe_clk);
        in_valid    = 1'b0;
        overrun_clr = 1'b0;
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL overrun_set_wins: overrun=%b required 1", overrun);
        else pass_cnt++;
        wait_result(got, lat);
        total_cnt++;
        if (got != m_y) $display("FAIL result_after_drop: y=%0d required %0d", got, m_y);
        else pass_cnt++;
        overrun_clr = 1'b1;
        @(negedge ffe_clk);
        overrun_clr = 1'b0;
    endtask

    task automatic test_reset_mid_mac();
        int got;
        bit seen;
        load_bank(1024, 1024, 1024, 1024);
        accept_sample(300);
        @(negedge ffe_clk);
        rst = 1'b1;
        @(negedge ffe_clk);
        rst = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ffe_clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total_cnt++;
        if (seen) $display("FAIL abort_no_out_valid: out_valid seen=1 required 0");
        else pass_cnt++;
        total_cnt++;
        if (y !== '0 || in_ready !== 1'b1) $display("FAIL abort_state: y=%0d in_ready=%b required 0 and 1", y, in_ready);
        else pass_cnt++;
        load_bank(1024, 1024, 1024, 1024);
        send_sample(10, got);
        total_cnt++;
        if (got != 10) $display("FAIL abort_line_cleared: y=%0d required 10", got);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int got;
        do_reset();
        load_bank(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
                  int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
        for (int n = 0; n < 40; n++) begin
            if (n % 8 == 7) begin
                write_coef(int'($urandom_range(NUM_TAPS - 1)), int'($urandom_range(4095)) - 2048);
                commit();
            end
            send_sample(int'($urandom_range(4095)) - 2048, got);
        end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        d_in         = '0;
        coef_wr_en   = 1'b0;
        coef_wr_addr = '0;
        coef_wr_data = '0;
        coef_commit  = 1'b0;
        overrun_clr  = 1'b0;
        test_reset();
        test_identity();
        test_impulse();
        test_rounding();
        test_saturation();
        test_overrun_commit();
        test_reset_mid_mac();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
